// File: rtl/traffic_pkg.sv
// Shared phase encoding and parameter-legality helper for the N-approach
// traffic phase controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_ALL_RED = 2'd0,
    PH_GREEN   = 2'd1,
    PH_YELLOW  = 2'd2
  } phase_e;

  // Elaboration-time legality check, evaluated by the top level.
  function automatic bit params_legal(input int n_approach, input int cnt_w,
                                      input int t_min, input int t_max,
                                      input int t_yel, input int t_ar);
    return (n_approach >= 32'sd2) && (n_approach <= 32'sd16) &&
           (cnt_w >= 32'sd1) && (cnt_w <= 32'sd30) &&
           ((32'sd1 << cnt_w) > t_max) &&
           (t_min >= 32'sd1) && (t_max >= t_min) &&
           (t_yel >= 32'sd1) && (t_ar >= 32'sd1);
  endfunction

endpackage

// File: rtl/rr_next_select.sv
// Wrap-around priority scan: first approach with a waiting vehicle after
// 'active', with 'active' itself considered last.
module rr_next_select
  import traffic_pkg::*;
#(
  parameter int N_APPROACH = 4,
  localparam int IDX_W = $clog2(N_APPROACH)
) (
  input  logic [N_APPROACH-1:0] sensor,
  input  logic [IDX_W-1:0]      active,
  output logic [IDX_W-1:0]      next_idx,
  output logic                  found
);

  logic [IDX_W-1:0] idx_s;

  // Scan active+1 .. active+N (mod N); first hit wins.
  always_comb begin
    next_idx = active;
    found    = 1'b0;
    idx_s    = active;
    for (int k = 1; k <= N_APPROACH; k++) begin
      idx_s = IDX_W'((int'(active) + k) % N_APPROACH);
      if (!found && sensor[idx_s]) begin
        next_idx = idx_s;
        found    = 1'b1;
      end else begin
        next_idx = next_idx;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_controller.sv
// Round-robin N-approach signal controller: phase FSM, phase timer and
// registered one-hot lamp decode.
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int N_APPROACH  = 4,
  parameter int CNT_W       = 8,
  parameter int T_MIN_GREEN = 4,
  parameter int T_MAX_GREEN = 10,
  parameter int T_YELLOW    = 2,
  parameter int T_ALL_RED   = 1,
  localparam int IDX_W = $clog2(N_APPROACH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_APPROACH-1:0] sensor,
  output logic [N_APPROACH-1:0] green,
  output logic [N_APPROACH-1:0] yellow,
  output logic [N_APPROACH-1:0] red,
  output logic [IDX_W-1:0]      active,
  output logic [1:0]            phase
);

  if (!params_legal(N_APPROACH, CNT_W, T_MIN_GREEN, T_MAX_GREEN, T_YELLOW, T_ALL_RED))
  begin : g_param_check
    $error("traffic_phase_controller: illegal parameter set");
  end

  localparam logic [CNT_W-1:0]      MIN_LAST = CNT_W'(T_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0]      MAX_LAST = CNT_W'(T_MAX_GREEN - 1);
  localparam logic [CNT_W-1:0]      Y_LAST   = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0]      AR_LAST  = CNT_W'(T_ALL_RED - 1);
  localparam logic [N_APPROACH-1:0] ONE_LSB  = N_APPROACH'(1);

  phase_e                  phase_q, phase_d;
  logic [IDX_W-1:0]        active_q, active_d;
  logic [CNT_W-1:0]        t_q, t_d;
  logic [N_APPROACH-1:0]   green_q, green_d;
  logic [N_APPROACH-1:0]   yellow_q, yellow_d;
  logic [N_APPROACH-1:0]   red_q, red_d;
  logic [IDX_W-1:0]        next_idx_s;
  logic                    found_s;
  logic                    own_req_s;
  logic                    other_req_s;

  rr_next_select #(.N_APPROACH(N_APPROACH)) u_rr (
    .sensor   (sensor),
    .active   (active_q),
    .next_idx (next_idx_s),
    .found    (found_s)
  );

  assign own_req_s   = sensor[active_q];
  assign other_req_s = |(sensor & ~(ONE_LSB << active_q));

  // Next phase/timer/active plus lamp decode of the next state, so the
  // lamp registers always agree with the registered phase and active.
  always_comb begin
    phase_d  = phase_q;
    active_d = active_q;
    t_d      = t_q;
    case (phase_q)
      PH_GREEN: begin
        if ((t_q >= MIN_LAST) && other_req_s && (!own_req_s || (t_q >= MAX_LAST))) begin
          phase_d = PH_YELLOW;
          t_d     = '0;
        end else if (t_q < MAX_LAST) begin
          t_d = t_q + CNT_W'(1);
        end else begin
          t_d = t_q;
        end
      end
      PH_YELLOW: begin
        if (t_q == Y_LAST) begin
          phase_d = PH_ALL_RED;
          t_d     = '0;
        end else begin
          t_d = t_q + CNT_W'(1);
        end
      end
      PH_ALL_RED: begin
        if (t_q == AR_LAST) begin
          phase_d  = PH_GREEN;
          active_d = found_s ? next_idx_s : active_q;
          t_d      = '0;
        end else begin
          t_d = t_q + CNT_W'(1);
        end
      end
      default: begin
        phase_d = PH_ALL_RED;
        t_d     = '0;
      end
    endcase

    green_d  = (phase_d == PH_GREEN)  ? (ONE_LSB << active_d) : '0;
    yellow_d = (phase_d == PH_YELLOW) ? (ONE_LSB << active_d) : '0;
    red_d    = ~(green_d | yellow_d);
  end

  // Phase FSM state, timer and registered lamp outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q  <= PH_ALL_RED;
      active_q <= '0;
      t_q      <= '0;
      green_q  <= '0;
      yellow_q <= '0;
      red_q    <= '1;
    end else begin
      phase_q  <= phase_d;
      active_q <= active_d;
      t_q      <= t_d;
      green_q  <= green_d;
      yellow_q <= yellow_d;
      red_q    <= red_d;
    end
  end

  assign green  = green_q;
  assign yellow = yellow_q;
  assign red    = red_q;
  assign active = active_q;
  assign phase  = phase_q;

endmodule
